// File: rtl/snake_board_map_pkg.sv
// snake_board_map_pkg: shared play-field geometry, direction and FSM encodings
package snake_board_map_pkg;

    localparam int H_LOGIC_WIDTH = 5;
    localparam int V_LOGIC_WIDTH = 5;
    localparam int H_LOGIC_MAX   = 31;
    localparam int V_LOGIC_MAX   = 23;
    localparam int CNT_WIDTH     = 10;

    typedef enum logic [1:0] {
        UP    = 2'b00,
        RIGHT = 2'b01,
        LEFT  = 2'b10,
        DOWN  = 2'b11
    } dir_t;

    typedef enum logic [1:0] {
        CLEAR = 2'b00,
        RUN   = 2'b01,
        DEAD  = 2'b10
    } state_t;

    // true when (x,y) lies inside the logical play field
    function automatic logic cell_ok(input logic [H_LOGIC_WIDTH-1:0] x,
                                     input logic [V_LOGIC_WIDTH-1:0] y);
        return int'(x) <= H_LOGIC_MAX && int'(y) <= V_LOGIC_MAX;
    endfunction

endpackage

// File: rtl/snake_map_ram.sv
// snake_map_ram: one-bit-per-cell row array with row clear, cell set/clear and registered read
module snake_map_ram
    import snake_board_map_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     row_clr,
    input  logic [V_LOGIC_WIDTH-1:0] row_y,
    input  logic                     set_en,
    input  logic [H_LOGIC_WIDTH-1:0] set_x,
    input  logic [V_LOGIC_WIDTH-1:0] set_y,
    input  logic                     clr_en,
    input  logic [H_LOGIC_WIDTH-1:0] clr_x,
    input  logic [V_LOGIC_WIDTH-1:0] clr_y,
    input  logic [H_LOGIC_WIDTH-1:0] peek_x,
    input  logic [V_LOGIC_WIDTH-1:0] peek_y,
    output logic                     peek,
    input  logic                     rd_en,
    input  logic [H_LOGIC_WIDTH-1:0] rd_x,
    input  logic [V_LOGIC_WIDTH-1:0] rd_y,
    output logic                     rd_occ
);

    logic [H_LOGIC_MAX:0] mem [V_LOGIC_MAX+1];

    // head-cell probe used for same-cycle collision detection
    assign peek = cell_ok(peek_x, peek_y) ? mem[peek_y][peek_x] : 1'b0;

    // map writes; set is last so a head landing on the vacated tail ends set
    always_ff @(posedge clk) begin
        if (row_clr) mem[row_y] <= '0;
        if (clr_en) mem[clr_y][clr_x] <= 1'b0;
        if (set_en) mem[set_y][set_x] <= 1'b1;
    end

    // renderer read: registered, pre-update value, 0 when off-field or disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_occ <= 1'b0;
        else rd_occ <= rd_en && cell_ok(rd_x, rd_y) && mem[rd_y][rd_x];
    end

endmodule

// File: rtl/snake_board_map.sv
// snake_board_map: occupancy map with clear sweep, self-collision flag and cell count
module snake_board_map
    import snake_board_map_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     upd,
    input  logic                     score,
    input  logic [H_LOGIC_WIDTH-1:0] head_x,
    input  logic [V_LOGIC_WIDTH-1:0] head_y,
    input  logic [H_LOGIC_WIDTH-1:0] tail_x,
    input  logic [V_LOGIC_WIDTH-1:0] tail_y,
    input  logic [H_LOGIC_WIDTH-1:0] rd_x,
    input  logic [V_LOGIC_WIDTH-1:0] rd_y,
    output logic                     rd_occ,
    output logic                     busy,
    output logic                     collision,
    output logic [CNT_WIDTH-1:0]     occ_count
);

    state_t                   state;
    logic [V_LOGIC_WIDTH-1:0] row;
    logic                     head_occ;
    logic                     same_cell;
    logic                     hit;
    logic                     step;

    assign busy      = state == CLEAR;
    assign same_cell = {head_x, head_y} == {tail_x, tail_y};
    assign hit       = !cell_ok(head_x, head_y) || (head_occ && !(!score && same_cell));
    assign step      = !clear && state == RUN && upd && !hit;

    snake_map_ram u_ram (
        .clk    (clk),
        .rst_n  (rst_n),
        .row_clr(busy),
        .row_y  (row),
        .set_en (step),
        .set_x  (head_x),
        .set_y  (head_y),
        .clr_en (step && !score && cell_ok(tail_x, tail_y)),
        .clr_x  (tail_x),
        .clr_y  (tail_y),
        .peek_x (head_x),
        .peek_y (head_y),
        .peek   (head_occ),
        .rd_en  (!busy && !clear),
        .rd_x   (rd_x),
        .rd_y   (rd_y),
        .rd_occ (rd_occ)
    );

    // clear sweep, step evaluation and sticky collision
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || clear) begin
            state     <= CLEAR;
            row       <= '0;
            collision <= 1'b0;
            occ_count <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    row <= row + 1'b1;
                    if (row == V_LOGIC_WIDTH'(V_LOGIC_MAX)) state <= RUN;
                end
                RUN: if (upd) begin
                    if (hit) begin
                        collision <= 1'b1;
                        state     <= DEAD;
                    end else if (score && occ_count != '1) begin
                        occ_count <= occ_count + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_snake_board_map.sv
// tb_snake_board_map: directed plan plus randomized steps against a cell-array model
module tb_snake_board_map;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear = 1'b0;
    logic       upd = 1'b0;
    logic       score = 1'b0;
    logic [4:0] head_x = '0, head_y = '0, tail_x = '0, tail_y = '0, rd_x = '0, rd_y = '0;
    logic       rd_occ, busy, collision;
    logic [9:0] occ_count;

    int total = 0;
    int bad = 0;
    bit m [24][32];
    int cnt = 0;
    bit dead = 0;

    always #5 clk = ~clk;

    snake_board_map dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .upd      (upd),
        .score    (score),
        .head_x   (head_x),
        .head_y   (head_y),
        .tail_x   (tail_x),
        .tail_y   (tail_y),
        .rd_x     (rd_x),
        .rd_y     (rd_y),
        .rd_occ   (rd_occ),
        .busy     (busy),
        .collision(collision),
        .occ_count(occ_count)
    );

    function automatic bit mget(input int x, input int y);
        return (x >= 0 && x <= 31 && y >= 0 && y <= 23) ? m[y][x] : 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, want);
        end
    endtask

    task automatic model_wipe();
        for (int y = 0; y < 24; y++)
            for (int x = 0; x < 32; x++)
                m[y][x] = 1'b0;
        cnt = 0;
        dead = 0;
    endtask

    task automatic busy_len(input string tag);
        int n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk(tag, n, 24);
    endtask

    task automatic query(input int x, input int y);
        rd_x = 5'(x);
        rd_y = 5'(y);
        @(negedge clk);
        chk("rd_occ", rd_occ, mget(x, y));
    endtask

    task automatic step(input int hx, input int hy, input int tx, input int ty, input int sc,
                        input int qx, input int qy);
        bit want_rd;
        want_rd = mget(qx, qy);
        head_x = 5'(hx); head_y = 5'(hy);
        tail_x = 5'(tx); tail_y = 5'(ty);
        score = sc != 0;
        rd_x = 5'(qx); rd_y = 5'(qy);
        upd = 1'b1;
        @(negedge clk);
        upd = 1'b0;
        if (!dead) begin
            if (hx > 31 || hy > 23 || (mget(hx, hy) && !(sc == 0 && hx == tx && hy == ty))) begin
                dead = 1;
            end else begin
                if (sc == 0 && tx <= 31 && ty <= 23) m[ty][tx] = 1'b0;
                m[hy][hx] = 1'b1;
                if (sc != 0 && cnt < 1023) cnt++;
            end
        end
        chk("step_collision", collision, dead);
        chk("step_count", occ_count, cnt);
        chk("step_rd", rd_occ, want_rd);
    endtask

    task automatic do_clear(input bit with_upd);
        clear = 1'b1;
        upd = with_upd;
        head_x = 5'd4; head_y = 5'd4; score = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        upd = 1'b0;
        model_wipe();
        busy_len("clear_busy_len");
        chk("clear_collision", collision, 0);
        chk("clear_count", occ_count, 0);
    endtask

    initial begin
        model_wipe();
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1);
        chk("rst_collision", collision, 0);
        chk("rst_count", occ_count, 0);
        chk("rst_rd", rd_occ, 0);
        rst_n = 1'b1;
        busy_len("rst_busy_len");
        query(0, 0);
        query(31, 23);
        chk("run_count0", occ_count, 0);
        chk("run_collision0", collision, 0);
        // growth
        step(5, 5, 0, 0, 1, 0, 0);
        step(6, 5, 0, 0, 1, 0, 0);
        query(5, 5);
        query(6, 5);
        query(7, 5);
        chk("grow_count", occ_count, 2);
        // move with a same-cycle query of the new head
        step(7, 5, 5, 5, 0, 7, 5);
        query(7, 5);
        query(5, 5);
        chk("move_count", occ_count, 2);
        // tail chase
        step(1, 1, 0, 0, 1, 0, 0);
        step(2, 1, 0, 0, 1, 0, 0);
        step(2, 2, 0, 0, 1, 0, 0);
        step(1, 2, 0, 0, 1, 0, 0);
        step(1, 1, 1, 1, 0, 1, 1);
        query(1, 1);
        chk("chase_collision", collision, 0);
        // self-hit then frozen map
        step(6, 5, 2, 1, 0, 6, 5);
        chk("hit_collision", collision, 1);
        step(10, 10, 0, 0, 1, 10, 10);
        query(10, 10);
        // bounds and restart with a same-cycle upd
        do_clear(1'b0);
        step(3, 24, 0, 0, 0, 3, 24);
        chk("oob_collision", collision, 1);
        do_clear(1'b1);
        query(4, 4);
        query(0, 0);
        query(31, 23);
        for (int i = 0; i < 8; i++) query(int'($urandom_range(31)), int'($urandom_range(23)));
        // randomized steps
        for (int i = 0; i < 400; i++) begin
            if (dead && $urandom_range(3) == 0) begin
                do_clear(1'($urandom_range(1)));
            end else begin
                int hx, hy, tx, ty;
                hx = int'($urandom_range(31));
                hy = int'($urandom_range(25));
                tx = int'($urandom_range(31));
                ty = int'($urandom_range(25));
                if ($urandom_range(7) == 0) begin
                    tx = hx;
                    ty = hy;
                end
                step(hx, hy, tx, ty, int'($urandom_range(1)),
                     int'($urandom_range(31)), int'($urandom_range(25)));
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/snake_board_map.md
Name: snake_board_map

Overview:
- Occupancy map of the 32x24 logical play field, downstream of the snake body stage.
- Consumes the per-step new head cell and vacated tail cell; keeps one bit per cell.
- Flags self-collision and serves a registered cell-lookup port to the VGA renderer.
- Reports the occupied-cell count to game control.

Parameters:
- H_LOGIC_WIDTH, 5, column coordinate width
- V_LOGIC_WIDTH, 5, row coordinate width
- H_LOGIC_MAX, 31, last valid column
- V_LOGIC_MAX, 23, last valid row
- CNT_WIDTH, 10, occupied-count width; must hold (H_LOGIC_MAX+1)*(V_LOGIC_MAX+1)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous one-cycle pulse: restart the board-clear sweep
- upd  in  1  one-cycle step strobe; head/tail/score sampled this cycle
- score  in  1  this step grows the snake (tail is not vacated)
- head_x  in  H_LOGIC_WIDTH  new head column
- head_y  in  V_LOGIC_WIDTH  new head row
- tail_x  in  H_LOGIC_WIDTH  cell vacated this step (ignored when score=1)
- tail_y  in  V_LOGIC_WIDTH  row of vacated cell
- rd_x  in  H_LOGIC_WIDTH  renderer query column
- rd_y  in  V_LOGIC_WIDTH  renderer query row
- rd_occ  out  1  occupancy of (rd_x,rd_y), 1-cycle latency
- busy  out  1  clear sweep in progress
- collision  out  1  sticky self-collision flag
- occ_count  out  CNT_WIDTH  number of set cells

Behaviour:
- Reset and clock: rst_n low asynchronously forces state CLEAR, row counter 0, busy=1, collision=0, occ_count=0, rd_occ=0. The map array itself is not reset; the sweep clears it.
- Storage: V_LOGIC_MAX+1 rows of H_LOGIC_MAX+1 bits, addressed as occ[y][x].
- State CLEAR: zero one row per cycle, row 0 to V_LOGIC_MAX, so busy=1 for exactly 24 cycles after reset release. After the last row, go to RUN and busy=0 next cycle. upd is dropped in CLEAR; upstream holds off while busy.
- State RUN, upd=1, evaluated on the sampled inputs:
  - Head out of range (head_x>H_LOGIC_MAX or head_y>V_LOGIC_MAX): collision.
  - Head cell occupied and not (score=0 and head==tail): collision.
  - On collision: collision=1 on the next edge, go to DEAD, no map write, occ_count unchanged.
  - Otherwise set the head cell. If score=0, clear the tail cell; occ_count unchanged (unless head==tail, also unchanged, cell stays 1). If score=1, occ_count+1, saturating at its maximum.
  - Head==tail with score=0 (moving into the cell being vacated) is legal; the cell ends set.
  - An out-of-range tail with score=0 is a clear to nothing; no error.
- State DEAD: map frozen, upd ignored, collision held at 1.
- clear=1 in any state: next state CLEAR, row counter 0, collision=0, occ_count=0. clear overrides a same-cycle upd.
- Read port: rd_occ registered from occ[rd_y][rd_x]. An out-of-range query returns 0. While busy, rd_occ=0.
- Same-cycle read of a cell being written: rd_occ returns the pre-update value; the new value is visible from the next query.
- Latency: upd to map/collision/occ_count update is 1 clock.
- Reset asserted mid-sweep or mid-update: state immediately reverts to the reset values above; the sweep restarts after release.

Decomposition:
- Shared game package holds H/V widths and maxima, the direction encodings (UP=00, RIGHT=01, LEFT=10, DOWN=11) and the FSM state encoding (CLEAR, RUN, DEAD), so snake_body, the renderer and this block agree.
- One natural sub-module: snake_map_ram. It is the row array with one synchronous write/clear port and one registered read port; the FSM and counters stay in the top.

Test Plan:
- Reset release: busy=1 for exactly 24 cycles, then 0. A query at (0,0) and (31,23) gives rd_occ=0. occ_count=0, collision=0.
- Growth: upd with head (5,5), score=1; then head (6,5), score=1. Queries return 1 at (5,5) and (6,5), 0 at (7,5), and occ_count=2.
- Move: from that state, upd with head (7,5), tail (5,5), score=0. (5,5)=0, (7,5)=1, occ_count stays 2. A same-cycle query of (7,5) returns 0, and 1 on the following query.
- Tail chase: snake occupying (1,1),(2,1),(2,2),(1,2), upd with head (1,1) and tail (1,1), score=0. collision stays 0 and (1,1) stays 1.
- Self-hit: upd with head on an occupied non-tail cell. collision=1 one cycle later. A later upd to a free cell leaves the map and occ_count unchanged.
- Bounds/restart: upd with head (3,24) sets collision=1. A clear pulse with a same-cycle upd then gives busy for 24 cycles, collision=0, occ_count=0, and all queries 0.
